btn_arbiter: RTL and testbench

- Front-end controller for the board push-buttons.
- Synchronises N raw button inputs and detects rising edges.
- Shares a single lockout (debounce) timer between all buttons using round-robin arbitration.
- For each accepted press: issues a one-cycle clean pulse per button plus a valid/ready event carrying the button index, for the downstream control FSM.

---
 rtl/btn_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_btn_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btn_arbiter
// Purpose  : Push-button front end. Synchronises N raw button levels, detects
//            rising edges, queues presses in a pending vector and hands them
//            out one at a time through a shared lockout (debounce) timer.
//            Each accepted press gives a one-cycle clean pulse on its bit and
//            a valid/ready event carrying the button index.
// Ports    : clock      - system clock, rising edge
//            reset      - synchronous, active-high
//            raw[N]     - asynchronous button levels
//            clean[N]   - one-cycle pulse per accepted press
//            evt_valid  - event available
//            evt_id     - accepted button index, held while evt_valid=1
//            evt_ready  - consumer handshake
//            busy       - lockout timer running
//            overflow   - sticky, press arrived on an already-pending button
// Options  : BTN_ARB_FIXED_PRIO_EN - when defined, lowest pending index wins
//            and the round-robin pointer is removed; otherwise round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module btn_arbiter #(
  parameter int N       = 4,
  parameter int LOCKOUT = 4095,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = $clog2(LOCKOUT + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   raw,
  output logic [N-1:0]   clean,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic           busy,
  output logic           overflow
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  logic [N-1:0]   s1_q, s2_q, s3_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   clean_q, clean_d;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] evt_id_q, evt_id_d;
  logic           evt_valid_q, evt_valid_d;
  logic           busy_q, busy_d;
  logic           overflow_q, overflow_d;
`ifndef BTN_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_q, rr_d;
`endif

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_accept;
  logic           w_grant;
  logic [IDW-1:0] w_win;

`ifdef BTN_ARB_FIXED_PRIO_EN
  // Lowest set index wins.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] p);
    logic [IDW-1:0] w;
    w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) w = IDW'(i);
    end
    return w;
  endfunction
`else
  // First set bit at or above base, wrapping at N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] p,
                                          input logic [IDW-1:0] base);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx_w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      idx_w = IDW'(idx);
      if (!found && p[idx_w]) begin
        w     = idx_w;
        found = 1'b1;
      end
    end
    return w;
  endfunction
`endif

  assign w_rise  = s2_q & ~s3_q;
  // A held event stalls the arbiter so evt_id never changes under the consumer.
  assign w_grant = (state_q == ST_IDLE) && (pend_q != '0) && !evt_valid_q;

`ifdef BTN_ARB_FIXED_PRIO_EN
  assign w_win = pick(pend_q);
`else
  assign w_win = pick(pend_q, rr_q);
`endif

  // Edges of the locked-out button are bounce, as is an edge on the button
  // being granted this very cycle.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N; i++) begin
      w_accept[i] = w_rise[i]
                  && !((state_q == ST_LOCK) && (lock_id_q == IDW'(i)))
                  && !(w_grant && (w_win == IDW'(i)));
    end
  end

  always_comb begin
    pend_d      = pend_q;
    clean_d     = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_id_d   = lock_id_q;
    evt_id_d    = evt_id_q;
    evt_valid_d = evt_valid_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
`ifndef BTN_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (w_grant) begin
        clean_d        = N'(1) << w_win;
        pend_d[w_win]  = 1'b0;
        evt_valid_d    = 1'b1;
        evt_id_d       = w_win;
        lock_id_d      = w_win;
        cnt_d          = CW'(LOCKOUT - 1);
        state_d        = ST_LOCK;
        busy_d         = 1'b1;
`ifndef BTN_ARB_FIXED_PRIO_EN
        rr_d           = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
`endif
      end
    end else begin
      // Counter is loaded with LOCKOUT-1 so busy is high for LOCKOUT cycles.
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    for (int i = 0; i < N; i++) begin
      if (w_accept[i]) begin
        if (pend_q[i]) overflow_d = 1'b1;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pend_q      <= '0;
      clean_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lock_id_q   <= '0;
      evt_id_q    <= '0;
      evt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifndef BTN_ARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pend_q      <= pend_d;
      clean_q     <= clean_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_id_q   <= lock_id_d;
      evt_id_q    <= evt_id_d;
      evt_valid_q <= evt_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
`ifndef BTN_ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign clean     = clean_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_arbiter
// Purpose  : Directed self-checking bench for btn_arbiter (N=4, LOCKOUT=15).
//            Inputs change and outputs are sampled on the falling clock edge.
//            Tick t counts falling edges after the stimulus at t=0, so a raw
//            edge applied at t=0 gives its clean pulse at t=4.
// Options  : BTN_ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] clean;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  btn_arbiter #(
    .N       (4),
    .LOCKOUT (15)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw),
    .clean     (clean),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic apply_reset;
    reset     = 1'b1;
    raw       = 4'b0000;
    evt_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    n_checks++;
    if (clean !== 4'b0000) begin n_fail++; $display("FAIL reset_clean got %b want 0000", clean); end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid got %b want 0", evt_valid); end
    n_checks++;
    if (evt_id !== 2'd0) begin n_fail++; $display("FAIL reset_evt_id got %0d want 0", evt_id); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single_press;
    int busy_cnt = 0;
    int extra    = 0;
    apply_reset();
    raw = 4'b0010;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 4) begin
        n_checks++;
        if (clean !== 4'b0010) begin n_fail++; $display("FAIL single_clean got %b want 0010", clean); end
        n_checks++;
        if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", evt_valid); end
        n_checks++;
        if (evt_id !== 2'd1) begin n_fail++; $display("FAIL single_id got %0d want 1", evt_id); end
      end else if (clean !== 4'b0000) begin
        extra++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (t == 18) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last got %b want 1", busy); end
      end
      if (t == 19) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
      end
    end
    n_checks++;
    if (busy_cnt != 15) begin n_fail++; $display("FAIL single_busy_cycles got %0d want 15", busy_cnt); end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL single_held_repulse got %0d want 0", extra); end
  endtask

  task automatic test_bounce;
    int pulses = 0;
    apply_reset();
    raw = 4'b0001;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 4) begin
        n_checks++;
        if (clean !== 4'b0001) begin n_fail++; $display("FAIL bounce_first got %b want 0001", clean); end
      end
      if (clean[0] === 1'b1) pulses++;
      if (t >= 4 && t < 16) raw[0] = (((t - 4) / 2) % 2) == 1;
      if (t == 16) raw[0] = 1'b0;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL bounce_overflow got %b want 0", overflow); end
  endtask

  task automatic test_round_robin;
    int         exp_order [6];
    int         n_exp;
    logic [3:0] exp_clean;
    logic [3:0] one;
`ifdef BTN_ARB_FIXED_PRIO_EN
    exp_order = '{0, 1, 0, 2, 0, 3};
    n_exp     = 6;
`else
    exp_order = '{0, 1, 2, 3, 0, 0};
    n_exp     = 4;
`endif
    one = 4'b0001;
    apply_reset();
    raw = 4'b1111;
    for (int t = 1; t <= 90; t++) begin
      tick();
      exp_clean = 4'b0000;
      for (int k = 0; k < n_exp; k++) begin
        if (t == 4 + 16 * k) exp_clean = one << exp_order[k];
      end
      n_checks++;
      if (clean !== exp_clean) begin
        n_fail++;
        $display("FAIL arb_order t=%0d clean got %b want %b", t, clean, exp_clean);
      end
`ifdef BTN_ARB_FIXED_PRIO_EN
      // Release and re-press button 0 inside every lockout window.
      if (t >= 4 && ((t - 4) % 16) == 2) raw[0] = 1'b0;
      if (t >= 4 && ((t - 4) % 16) == 8) raw[0] = 1'b1;
`endif
    end
  endtask

  task automatic test_back_pressure;
    int stall_pulses = 0;
    apply_reset();
    evt_ready = 1'b0;
    raw       = 4'b0100;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 4) begin
        n_checks++;
        if (clean !== 4'b0100) begin n_fail++; $display("FAIL bp_first got %b want 0100", clean); end
        n_checks++;
        if (evt_id !== 2'd2) begin n_fail++; $display("FAIL bp_first_id got %0d want 2", evt_id); end
      end
      if (t == 5) raw = 4'b1100;
      if (t > 4 && t < 27 && clean !== 4'b0000) stall_pulses++;
      if (t == 25) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got %b want 0", busy); end
        n_checks++;
        if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got %b want 1", evt_valid); end
        n_checks++;
        if (evt_id !== 2'd2) begin n_fail++; $display("FAIL bp_held_id got %0d want 2", evt_id); end
        evt_ready = 1'b1;
      end
      if (t == 26) begin
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ack_valid got %b want 0", evt_valid); end
      end
      if (t == 27) begin
        n_checks++;
        if (clean !== 4'b1000) begin n_fail++; $display("FAIL bp_grant3 got %b want 1000", clean); end
        n_checks++;
        if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_grant3_valid got %b want 1", evt_valid); end
        n_checks++;
        if (evt_id !== 2'd3) begin n_fail++; $display("FAIL bp_grant3_id got %0d want 3", evt_id); end
      end
    end
    n_checks++;
    if (stall_pulses != 0) begin n_fail++; $display("FAIL bp_stall_pulses got %0d want 0", stall_pulses); end
  endtask

  task automatic test_overflow;
    int c1 = 0;
    apply_reset();
    raw = 4'b0001;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (clean[1] === 1'b1) c1++;
      if (t == 4) begin
        n_checks++;
        if (clean !== 4'b0001) begin n_fail++; $display("FAIL ovf_first got %b want 0001", clean); end
      end
      if (t == 10) begin
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
      if (t == 16) begin
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
      end
      if (t == 20) begin
        n_checks++;
        if (clean !== 4'b0010) begin n_fail++; $display("FAIL ovf_grant1 got %b want 0010", clean); end
      end
      if (t == 5)  raw = 4'b0011;
      if (t == 8)  raw = 4'b0001;
      if (t == 11) raw = 4'b0011;
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_checks++;
    if (c1 != 1) begin n_fail++; $display("FAIL ovf_pulses1 got %0d want 1", c1); end
  endtask

  task automatic test_reset_mid_lockout;
    int late = 0;
    apply_reset();
    evt_ready = 1'b0;
    raw       = 4'b0010;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 5) raw = 4'b0110;
    end
    n_checks++;
    if (busy !== 1'b1 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre busy=%b valid=%b want 1 1", busy, evt_valid);
    end
    reset = 1'b1;
    raw   = 4'b0000;
    tick();
    n_checks++;
    if (clean !== 4'b0000 || evt_valid !== 1'b0 || evt_id !== 2'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs clean=%b valid=%b id=%0d busy=%b ovf=%b want all 0",
               clean, evt_valid, evt_id, busy, overflow);
    end
    reset     = 1'b0;
    evt_ready = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (clean !== 4'b0000) late++;
    end
    n_checks++;
    if (late != 0) begin n_fail++; $display("FAIL rst_mid_stale_pulse got %0d want 0", late); end
  endtask

  initial begin
    reset     = 1'b1;
    raw       = 4'b0000;
    evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_back_pressure();
    test_overflow();
    test_reset_mid_lockout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
